// File: rtl/mfb_region_narrower.sv
// Replays each accepted REGIONS-wide MFB word as RATIO slices of REGIONS/RATIO regions (build option MFB_REGION_NARROWER_SKIP_EN skips slices with no packet data).
// Latency: 1 cycle from RX accept to first TX slice; one slice per cycle while tx_dst_rdy is high.
// Backpressure: single word buffer; rx_dst_rdy follows tx_dst_rdy combinationally on the last valid slice, so there is no bubble between words.
module mfb_region_narrower #(
    parameter int REGIONS     = 4,
    parameter int RATIO       = 2,
    parameter int REGION_SIZE = 8,
    parameter int BLOCK_SIZE  = 8,
    parameter int ITEM_WIDTH  = 8,
    parameter int META_WIDTH  = 8
) (
    input  logic                                                        clk,
    input  logic                                                        reset,
    input  logic [REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0]         rx_data,
    input  logic [REGIONS*META_WIDTH-1:0]                                rx_meta,
    input  logic [REGIONS*$clog2(REGION_SIZE)-1:0]                       rx_sof_pos,
    input  logic [REGIONS*$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]            rx_eof_pos,
    input  logic [REGIONS-1:0]                                           rx_sof,
    input  logic [REGIONS-1:0]                                           rx_eof,
    input  logic                                                        rx_src_rdy,
    output logic                                                        rx_dst_rdy,
    output logic [(REGIONS/RATIO)*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0] tx_data,
    output logic [(REGIONS/RATIO)*META_WIDTH-1:0]                        tx_meta,
    output logic [(REGIONS/RATIO)*$clog2(REGION_SIZE)-1:0]               tx_sof_pos,
    output logic [(REGIONS/RATIO)*$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]    tx_eof_pos,
    output logic [REGIONS/RATIO-1:0]                                     tx_sof,
    output logic [REGIONS/RATIO-1:0]                                     tx_eof,
    output logic                                                        tx_src_rdy,
    input  logic                                                        tx_dst_rdy
);
    localparam int TXR  = REGIONS / RATIO;
    localparam int DW   = REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH;
    localparam int SPW  = $clog2(REGION_SIZE);
    localparam int EPW  = $clog2(REGION_SIZE * BLOCK_SIZE);
    localparam int IDXW = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {EMPTY, SEND} state_t;

    state_t                   state, state_nxt;
    logic                     pkt_open;
    logic [RATIO-1:0]         mask_q;
    logic [IDXW-1:0]          idx_q;
    logic [REGIONS*DW-1:0]    buf_data;
    logic [REGIONS*META_WIDTH-1:0] buf_meta;
    logic [REGIONS*SPW-1:0]   buf_sof_pos;
    logic [REGIONS*EPW-1:0]   buf_eof_pos;
    logic [REGIONS-1:0]       buf_sof, buf_eof;

    logic [RATIO-1:0]         rx_mask;
    logic                     open_last;
    logic [IDXW-1:0]          first_idx, nxt_idx;
    logic                     last, cur_vld, slice_done, accept;

    // SOF+EOF in one region keeps the open state: either a whole packet, or an EOF closing one followed by a new SOF.
    function automatic logic next_open(input logic open_in, input logic sof, input logic eof);
        if (sof && eof) return open_in;
        if (sof)        return 1'b1;
        if (eof)        return 1'b0;
        return open_in;
    endfunction

    always_comb begin
        logic op;
        op      = pkt_open;
        rx_mask = '0;
        for (int k = 0; k < RATIO; k++) begin
            rx_mask[k] = op;
            for (int j = 0; j < TXR; j++) begin
                rx_mask[k] = rx_mask[k] | rx_sof[k*TXR+j] | rx_eof[k*TXR+j];
                op = next_open(op, rx_sof[k*TXR+j], rx_eof[k*TXR+j]);
            end
        end
        open_last = op;
    end

`ifdef MFB_REGION_NARROWER_SKIP_EN
    always_comb begin
        first_idx = '0;
        nxt_idx   = idx_q;
        last      = 1'b1;
        for (int k = RATIO - 1; k >= 0; k--) begin
            if (rx_mask[k])
                first_idx = IDXW'(k);
            if (mask_q[k] && (k > int'(idx_q))) begin
                nxt_idx = IDXW'(k);
                last    = 1'b0;
            end
        end
    end
`else
    // Every word walks all RATIO slices; empty ones just idle with tx_src_rdy low.
    always_comb begin
        first_idx = '0;
        nxt_idx   = idx_q + 1'b1;
        last      = (idx_q == IDXW'(RATIO - 1));
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = (rx_mask != '0) ? SEND : EMPTY;
        else if (slice_done && last)
            state_nxt = EMPTY;
    end

    always_comb begin
        cur_vld    = mask_q[idx_q];
        slice_done = (state == SEND) && (tx_dst_rdy || !cur_vld);
        rx_dst_rdy = !reset && ((state == EMPTY) || (slice_done && last));
        accept     = rx_src_rdy && rx_dst_rdy;
        tx_src_rdy = !reset && (state == SEND) && cur_vld;
        tx_data    = '0;
        tx_meta    = '0;
        tx_sof_pos = '0;
        tx_eof_pos = '0;
        tx_sof     = '0;
        tx_eof     = '0;
        if (!reset && (state == SEND)) begin
            tx_data    = buf_data[int'(idx_q)*TXR*DW +: TXR*DW];
            tx_meta    = buf_meta[int'(idx_q)*TXR*META_WIDTH +: TXR*META_WIDTH];
            tx_sof_pos = buf_sof_pos[int'(idx_q)*TXR*SPW +: TXR*SPW];
            tx_eof_pos = buf_eof_pos[int'(idx_q)*TXR*EPW +: TXR*EPW];
            tx_sof     = buf_sof[int'(idx_q)*TXR +: TXR];
            tx_eof     = buf_eof[int'(idx_q)*TXR +: TXR];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_open    <= 1'b0;
            mask_q      <= '0;
            idx_q       <= '0;
            buf_data    <= '0;
            buf_meta    <= '0;
            buf_sof_pos <= '0;
            buf_eof_pos <= '0;
            buf_sof     <= '0;
            buf_eof     <= '0;
        end else if (accept) begin
            pkt_open    <= open_last;
            mask_q      <= rx_mask;
            idx_q       <= first_idx;
            buf_data    <= rx_data;
            buf_meta    <= rx_meta;
            buf_sof_pos <= rx_sof_pos;
            buf_eof_pos <= rx_eof_pos;
            buf_sof     <= rx_sof;
            buf_eof     <= rx_eof;
        end else if (slice_done && !last) begin
            idx_q <= nxt_idx;
        end
    end
endmodule
